tmem_ctrl: RTL and testbench
============================

TMEM_CTRL -- requirements
Module: tmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, word-address width (1 Mword).
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter TAG_W, default 8, tag width.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- i_ad  in  DATA_W  CPU address/data bus.
- i_tag  in  TAG_W  CPU write tag.
- i_astb  in  1  address strobe.
- i_atomic  in  1  read-modify-write request, sampled with i_astb.
- i_rd  in  1  read op.
- i_wr  in  1  write op.
- mem_addr  out  ADDR_W  array word address.
- mem_we  out  1  array write enable.
- mem_wdata  out  DATA_W  array write data.
- mem_wtag  out  TAG_W  array write tag.
- mem_rdata  in  DATA_W  array read data, 1-cycle synchronous.
- mem_rtag  in  TAG_W  array read tag.
- o_data  out  DATA_W  read data to CPU.
- o_tag  out  TAG_W  read tag to CPU.
- waddr  out  ADDR_W  current latched word address (trace visibility).
- o_locked  out  1  RMW lock held.
- o_err  out  1  one-cycle protocol-error pulse.

Function
REQ-005 FSM states SHALL be IDLE, ADDR, RMW.
REQ-006 i_astb=1 in IDLE or ADDR SHALL latch waddr<=i_ad[ADDR_W-1:0] (upper bits ignored), o_locked<=i_atomic, next state ADDR.
REQ-007 i_rd=1 in ADDR (no astb, no wr) SHALL present mem_addr=waddr combinationally; mem_rdata/mem_rtag registered into o_data/o_tag on the following edge (o_data valid 2 edges after the rd edge, held until next read).
REQ-008 i_wr=1 in ADDR SHALL assert mem_we for exactly that cycle with mem_addr=waddr, mem_wdata=i_ad, mem_wtag=i_tag.
REQ-009 Non-locked rd or wr in ADDR SHALL increment waddr by 1 modulo 2^ADDR_W and remain in ADDR (sequential access); 'hFFFFF wraps to 0.
REQ-010 Locked rd in ADDR SHALL go to RMW without incrementing waddr.
REQ-011 wr in RMW SHALL write waddr, clear o_locked, go IDLE, no increment.
REQ-012 In RMW, i_astb or i_rd SHALL pulse o_err, be ignored, and keep lock and state.
REQ-013 i_rd and i_wr both high SHALL pulse o_err, perform no access, keep state and waddr.
REQ-014 i_rd or i_wr in IDLE SHALL pulse o_err and perform no access.
REQ-015 i_astb with i_rd/i_wr in the same cycle SHALL latch the address only; the op is ignored with o_err pulse.
REQ-016 mem_we SHALL be 0 in every cycle not covered by REQ-008/REQ-011.

Reset
REQ-017 reset=1 SHALL asynchronously force state IDLE, waddr=0, o_data=0, o_tag=0, mem_we=0, o_locked=0, o_err=0; mem_addr=0.
REQ-018 reset asserted mid-RMW SHALL drop lock with no write issued; first post-reset edge SHALL accept only i_astb.

Structure
REQ-019 Package tmem_pkg SHALL hold ADDR_W/DATA_W/TAG_W defaults and the state enum typedef.
REQ-020 Storage SHALL be a separate sub-module tag_ram (2^ADDR_W x (DATA_W+TAG_W), 1-cycle synchronous read, write-first), instantiated beside tmem_ctrl by the bench, not inside it.

Verification
REQ-021 astb ad='h12345, wr ad='hDEADBEEF_00000001 tag='h5A -> mem_we 1 cycle at 'h12345; waddr becomes 'h12346.
REQ-022 astb 'h12345, rd -> o_data='hDEADBEEF_00000001, o_tag='h5A two edges later.
REQ-023 astb 'hFFFFF, wr, wr -> writes at 'hFFFFF then 'h00000; waddr ends 'h00001.
REQ-024 astb 'h00100 atomic=1, rd, astb, wr 'h7 -> o_locked 1 through RMW, o_err on stray astb, write at 'h00100, o_locked 0, IDLE.
REQ-025 rd+wr together in ADDR, and rd in IDLE -> one o_err pulse each, mem_we stays 0, waddr unchanged.
REQ-026 reset asserted mid-RMW between edges -> all outputs zero immediately, no write, later rd without astb gives o_err.

Source files
------------

// File: rtl/tmem_pkg.sv
// Shared defaults and FSM state encoding for the tagged-memory controller.
package tmem_pkg;

   localparam int unsigned ADDR_W_DEF = 20;
   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned TAG_W_DEF  = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_RMW  = 2'd2
   } state_t;

endpackage : tmem_pkg

// File: rtl/tag_ram.sv
// Word-addressed data+tag storage with a 1-cycle synchronous, write-first read port.
module tag_ram
   import tmem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [TAG_W-1:0]  i_wtag,
   output logic [DATA_W-1:0] o_rdata,
   output logic [TAG_W-1:0]  o_rtag
);

   localparam int unsigned WORD_W = DATA_W + TAG_W;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rd;

   // Write port plus registered read; a same-cycle write is forwarded to the read register.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= {i_wdata, i_wtag};
         r_rd          <= {i_wdata, i_wtag};
      end else begin
         r_rd <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rd[WORD_W-1:TAG_W];
   assign o_rtag  = r_rd[TAG_W-1:0];

endmodule : tag_ram

// File: rtl/tmem_ctrl.sv
// CPU-side controller for a tagged word memory: address latch, sequential
// access with auto-increment, and a locked read-modify-write sequence.
module tmem_ctrl
   import tmem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_ad,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_astb,
   input  logic              i_atomic,
   input  logic              i_rd,
   input  logic              i_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [TAG_W-1:0]  mem_wtag,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [TAG_W-1:0]  mem_rtag,
   output logic [DATA_W-1:0] o_data,
   output logic [TAG_W-1:0]  o_tag,
   output logic [ADDR_W-1:0] waddr,
   output logic              o_locked,
   output logic              o_err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_waddr;
   logic                r_locked;
   logic                r_err;
   logic                r_rd_pend;
   logic [DATA_W-1:0]   r_data;
   logic [TAG_W-1:0]    r_tag;

   logic                w_latch;
   logic                w_rd;
   logic                w_wr;
   logic                w_incr;
   logic                w_err;
   logic                w_lock_clr;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and per-cycle access decode; illegal combinations raise an error and do nothing.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_rd        = 1'b0;
      w_wr        = 1'b0;
      w_incr      = 1'b0;
      w_err       = 1'b0;
      w_lock_clr  = 1'b0;
      case (r_state)
         S_IDLE, S_ADDR: begin
            if (i_astb) begin
               w_latch     = 1'b1;
               w_state_nxt = S_ADDR;
               w_err       = i_rd | i_wr;
            end else if (i_rd & i_wr) begin
               w_err = 1'b1;
            end else if (r_state == S_IDLE) begin
               w_err = i_rd | i_wr;
            end else if (i_rd) begin
               w_rd = 1'b1;
               if (r_locked) w_state_nxt = S_RMW;
               else          w_incr      = 1'b1;
            end else if (i_wr) begin
               // A locked write before the read keeps the address so the RMW stays on one word.
               w_wr   = 1'b1;
               w_incr = ~r_locked;
            end
         end
         S_RMW: begin
            if (i_astb | i_rd) begin
               w_err = 1'b1;
            end else if (i_wr) begin
               w_wr        = 1'b1;
               w_lock_clr  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Address, lock, error pulse and read-return registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waddr   <= '0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         r_rd_pend <= 1'b0;
         r_data    <= '0;
         r_tag     <= '0;
      end else begin
         r_err     <= w_err;
         r_rd_pend <= w_rd;
         if (r_rd_pend) begin
            r_data <= mem_rdata;
            r_tag  <= mem_rtag;
         end
         if (w_latch) begin
            r_waddr  <= i_ad[ADDR_W-1:0];
            r_locked <= i_atomic;
         end else if (w_incr) begin
            r_waddr <= r_waddr + ADDR_W'(1);
         end
         if (w_lock_clr) r_locked <= 1'b0;
      end
   end

   assign mem_addr  = r_waddr;
   assign mem_we    = w_wr;
   assign mem_wdata = i_ad;
   assign mem_wtag  = i_tag;
   assign o_data    = r_data;
   assign o_tag     = r_tag;
   assign waddr     = r_waddr;
   assign o_locked  = r_locked;
   assign o_err     = r_err;

endmodule : tmem_ctrl

// File: tb/tb_tmem_ctrl.sv
// Directed bench for tmem_ctrl with tag_ram alongside as the backing array.
module tb_tmem_ctrl;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned TAG_W  = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [DATA_W-1:0] i_ad = '0;
   logic [TAG_W-1:0]  i_tag = '0;
   logic              i_astb = 1'b0;
   logic              i_atomic = 1'b0;
   logic              i_rd = 1'b0;
   logic              i_wr = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [TAG_W-1:0]  mem_wtag;
   logic [DATA_W-1:0] mem_rdata;
   logic [TAG_W-1:0]  mem_rtag;
   logic [DATA_W-1:0] o_data;
   logic [TAG_W-1:0]  o_tag;
   logic [ADDR_W-1:0] waddr;
   logic              o_locked;
   logic              o_err;

   int n_vec = 0;
   int n_err = 0;
   int n_wr  = 0;

   always #5 clk = ~clk;

   tmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
      .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wtag(mem_wtag),
      .mem_rdata(mem_rdata), .mem_rtag(mem_rtag), .o_data(o_data), .o_tag(o_tag),
      .waddr(waddr), .o_locked(o_locked), .o_err(o_err)
   );

   tag_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_ram (
      .clk(clk), .i_addr(mem_addr), .i_we(mem_we), .i_wdata(mem_wdata),
      .i_wtag(mem_wtag), .o_rdata(mem_rdata), .o_rtag(mem_rtag)
   );

   // Count array writes actually committed on a clock edge.
   always @(posedge clk) if (mem_we) n_wr <= n_wr + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic astb, input logic atomic, input logic rd,
                        input logic wr, input logic [DATA_W-1:0] ad, input logic [TAG_W-1:0] tag);
      i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tag;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      #1;
      n_vec++; if (o_data !== 64'h0)     begin n_err++; $display("FAIL rst_o_data got %h want 0", o_data); end
      n_vec++; if (o_tag !== 8'h0)       begin n_err++; $display("FAIL rst_o_tag got %h want 0", o_tag); end
      n_vec++; if (waddr !== 20'h0)      begin n_err++; $display("FAIL rst_waddr got %h want 0", waddr); end
      n_vec++; if (mem_addr !== 20'h0)   begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
      n_vec++; if (mem_we !== 1'b0)      begin n_err++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
      n_vec++; if (o_locked !== 1'b0)    begin n_err++; $display("FAIL rst_locked got %b want 0", o_locked); end
      n_vec++; if (o_err !== 1'b0)       begin n_err++; $display("FAIL rst_err got %b want 0", o_err); end
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_write();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h12345, '0);
      step();
      n_vec++; if (waddr !== 20'h12345) begin n_err++; $display("FAIL wr_latch got %h want 12345", waddr); end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h5A);
      #1;
      n_vec++; if (mem_we !== 1'b1)         begin n_err++; $display("FAIL wr_we got %b want 1", mem_we); end
      n_vec++; if (mem_addr !== 20'h12345)  begin n_err++; $display("FAIL wr_addr got %h want 12345", mem_addr); end
      n_vec++; if (mem_wdata !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL wr_wdata got %h want deadbeef00000001", mem_wdata); end
      n_vec++; if (mem_wtag !== 8'h5A)      begin n_err++; $display("FAIL wr_wtag got %h want 5a", mem_wtag); end
      step();
      idle();
      #1;
      n_vec++; if (waddr !== 20'h12346) begin n_err++; $display("FAIL wr_incr got %h want 12346", waddr); end
      n_vec++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL wr_we_drop got %b want 0", mem_we); end
      n_vec++; if (o_err !== 1'b0)      begin n_err++; $display("FAIL wr_no_err got %b want 0", o_err); end
   endtask

   task automatic test_read();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h12345, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      #1;
      n_vec++; if (mem_addr !== 20'h12345) begin n_err++; $display("FAIL rd_addr got %h want 12345", mem_addr); end
      step();
      idle();
      n_vec++; if (o_data !== 64'h0)       begin n_err++; $display("FAIL rd_early got %h want 0", o_data); end
      n_vec++; if (waddr !== 20'h12346)    begin n_err++; $display("FAIL rd_incr got %h want 12346", waddr); end
      step();
      n_vec++; if (o_data !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL rd_data got %h want deadbeef00000001", o_data); end
      n_vec++; if (o_tag !== 8'h5A)        begin n_err++; $display("FAIL rd_tag got %h want 5a", o_tag); end
   endtask

   task automatic test_back_to_back_wrap();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hABC_FFFFF, '0);
      step();
      n_vec++; if (waddr !== 20'hFFFFF) begin n_err++; $display("FAIL wrap_latch got %h want fffff", waddr); end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hAAAA_0000_0000_1111, 8'h11);
      #1;
      n_vec++; if (mem_addr !== 20'hFFFFF || mem_we !== 1'b1) begin n_err++; $display("FAIL wrap_wr0 got %h/%b want fffff/1", mem_addr, mem_we); end
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hBBBB_0000_0000_2222, 8'h22);
      #1;
      n_vec++; if (mem_addr !== 20'h00000 || mem_we !== 1'b1) begin n_err++; $display("FAIL wrap_wr1 got %h/%b want 00000/1", mem_addr, mem_we); end
      step();
      idle();
      n_vec++; if (waddr !== 20'h00001) begin n_err++; $display("FAIL wrap_end got %h want 00001", waddr); end
      // Sequential read back across the wrap point.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFFF, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      step();
      step();
      idle();
      n_vec++; if (o_data !== 64'hAAAA_0000_0000_1111 || o_tag !== 8'h11) begin n_err++; $display("FAIL wrap_rd0 got %h/%h want aaaa000000001111/11", o_data, o_tag); end
      step();
      n_vec++; if (o_data !== 64'hBBBB_0000_0000_2222 || o_tag !== 8'h22) begin n_err++; $display("FAIL wrap_rd1 got %h/%h want bbbb000000002222/22", o_data, o_tag); end
   endtask

   task automatic test_rmw();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h00100, '0);
      step();
      n_vec++; if (o_locked !== 1'b1 || waddr !== 20'h00100) begin n_err++; $display("FAIL rmw_lock got %b/%h want 1/00100", o_locked, waddr); end
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      step();
      n_vec++; if (o_locked !== 1'b1 || waddr !== 20'h00100) begin n_err++; $display("FAIL rmw_rd got %b/%h want 1/00100", o_locked, waddr); end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h00555, '0);
      step();
      n_vec++; if (o_err !== 1'b1)      begin n_err++; $display("FAIL rmw_stray_err got %b want 1", o_err); end
      n_vec++; if (waddr !== 20'h00100 || o_locked !== 1'b1) begin n_err++; $display("FAIL rmw_stray_keep got %h/%b want 00100/1", waddr, o_locked); end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h7, 8'h03);
      #1;
      n_vec++; if (mem_we !== 1'b1 || mem_addr !== 20'h00100) begin n_err++; $display("FAIL rmw_wr got %b/%h want 1/00100", mem_we, mem_addr); end
      step();
      idle();
      n_vec++; if (o_locked !== 1'b0 || waddr !== 20'h00100 || o_err !== 1'b0) begin n_err++; $display("FAIL rmw_done got %b/%h/%b want 0/00100/0", o_locked, waddr, o_err); end
      // Back in IDLE, a bare read is a protocol error.
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      #1;
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL idle_rd_we got %b want 0", mem_we); end
      step();
      idle();
      n_vec++; if (o_err !== 1'b1)  begin n_err++; $display("FAIL idle_rd_err got %b want 1", o_err); end
      // Confirm the RMW write landed.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h00100, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      step();
      idle();
      step();
      n_vec++; if (o_data !== 64'h7 || o_tag !== 8'h03) begin n_err++; $display("FAIL rmw_readback got %h/%h want 7/03", o_data, o_tag); end
   endtask

   task automatic test_errors();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h00200, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h99, 8'h99);
      #1;
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rdwr_we got %b want 0", mem_we); end
      step();
      idle();
      n_vec++; if (o_err !== 1'b1 || waddr !== 20'h00200) begin n_err++; $display("FAIL rdwr_err got %b/%h want 1/00200", o_err, waddr); end
      step();
      n_vec++; if (o_err !== 1'b0)  begin n_err++; $display("FAIL rdwr_pulse got %b want 0", o_err); end
      // Strobe with a write: address taken, write dropped.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h00300, 8'h01);
      #1;
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL astbwr_we got %b want 0", mem_we); end
      step();
      idle();
      n_vec++; if (o_err !== 1'b1 || waddr !== 20'h00300) begin n_err++; $display("FAIL astbwr_err got %b/%h want 1/00300", o_err, waddr); end
   endtask

   task automatic test_reset_mid_rmw();
      int wr_before;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h00400, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      step();
      step();
      wr_before = n_wr;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h9, 8'h09);
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (o_locked !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL midrst_lock got %b/%b want 0/0", o_locked, mem_we); end
      n_vec++; if (o_data !== 64'h0 || o_tag !== 8'h0)  begin n_err++; $display("FAIL midrst_data got %h/%h want 0/0", o_data, o_tag); end
      n_vec++; if (waddr !== 20'h0 || mem_addr !== 20'h0 || o_err !== 1'b0) begin n_err++; $display("FAIL midrst_addr got %h/%h/%b want 0/0/0", waddr, mem_addr, o_err); end
      step();
      reset = 1'b0;
      n_vec++; if (n_wr !== wr_before) begin n_err++; $display("FAIL midrst_nowrite got %0d want %0d", n_wr, wr_before); end
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      step();
      idle();
      n_vec++; if (o_err !== 1'b1 || o_locked !== 1'b0) begin n_err++; $display("FAIL midrst_rd_err got %b/%b want 1/0", o_err, o_locked); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back_wrap();
      test_rmw();
      test_errors();
      test_reset_mid_rmw();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_tmem_ctrl
